// File: rtl/fetch_pkg.sv
// Shared definitions for the ROM fetch sequencer: default widths, the halt
// opcode and the fetch FSM state encoding.
package fetch_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  // Opcode that stops fetching once the word carrying it is accepted.
  localparam logic [3:0] HALT_OPC_DEF = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter for the fetch sequencer. Load beats increment; the count
// wraps naturally at 2^ADDR_W.
module pc_counter
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // PC register: reset to 0, load wins over increment, modulo-2^ADDR_W step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Address generator and fetch stage for the combinational program ROM.
// Drives the PC onto the ROM address bus, captures the returned byte and
// offers it downstream as opcode/operand under a valid/ready handshake.
module rom_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                  ADDR_W   = ADDR_W_DEF,
  parameter int                  DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W/2-1:0] HALT_OPC = HALT_OPC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                load,
  input  logic [ADDR_W-1:0]   load_addr,
  output logic [ADDR_W-1:0]   direccion,
  input  logic [DATA_W-1:0]   rom_data,
  output logic [DATA_W/2-1:0] opcode,
  output logic [DATA_W/2-1:0] operand,
  output logic                valid,
  input  logic                ready,
  output logic                halted
);

  localparam int OPC_W = DATA_W / 2;

  state_t              state;
  logic [DATA_W-1:0]   fetch_reg;
  logic [ADDR_W-1:0]   pc;
  logic                accept;

  // A word is consumed when downstream takes it while we are presenting it.
  assign accept = (state == S_HOLD) && ready;

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_addr (load_addr),
    .inc       (accept),
    .pc        (pc)
  );

  // Address goes straight from the PC flop to the ROM; no extra delay.
  assign direccion = pc;
  assign opcode    = fetch_reg[DATA_W-1:OPC_W];
  assign operand   = fetch_reg[OPC_W-1:0];

  // Fetch FSM with registered valid/halted; reset beats load beats state logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fetch_reg <= '0;
      valid     <= 1'b0;
      halted    <= 1'b0;
    end else if (load) begin
      // New PC: any pending word is flushed and the sequencer restarts idle.
      state  <= S_IDLE;
      valid  <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // ROM is combinational, so rom_data already reflects the current PC.
          fetch_reg <= rom_data;
          valid     <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          // Valid is never withdrawn here except by acceptance.
          if (ready) begin
            valid <= 1'b0;
            if (fetch_reg[DATA_W-1:OPC_W] == HALT_OPC) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else if (enable) begin
              state <= S_FETCH;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          // Parked until load or reset; enable is ignored.
          valid  <= 1'b0;
          halted <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Bench for rom_fetch_sequencer: directed scenarios plus a randomized run,
// all checked against a transaction-level reference model of the fetch rules.
module tb_rom_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [11:0] load_addr;
  logic [11:0] direccion;
  logic [7:0]  rom_data;
  logic [3:0]  opcode;
  logic [3:0]  operand;
  logic        valid;
  logic        ready;
  logic        halted;

  logic [7:0]  rom [0:4095];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: PC, last captured word, word-pending flag, halted flag,
  // and whether a ROM read is scheduled for the next edge.
  logic [11:0] m_pc;
  logic [7:0]  m_word;
  logic        m_valid;
  logic        m_halted;
  logic        m_fetch;

  always #5 clk = ~clk;

  assign rom_data = rom[direccion];

  rom_fetch_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .load_addr (load_addr),
    .direccion (direccion),
    .rom_data  (rom_data),
    .opcode    (opcode),
    .operand   (operand),
    .valid     (valid),
    .ready     (ready),
    .halted    (halted)
  );

  function automatic logic [21:0] obs();
    return {direccion, valid, halted, opcode, operand};
  endfunction

  function automatic logic [21:0] expv();
    return {m_pc, m_valid, m_halted, m_word};
  endfunction

  // Advance one clock and apply the fetch rules to the model using the inputs
  // that were present at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 12'h000; m_word = 8'h00; m_valid = 1'b0; m_halted = 1'b0; m_fetch = 1'b0;
    end else if (load) begin
      m_pc = load_addr; m_valid = 1'b0; m_halted = 1'b0; m_fetch = 1'b0;
    end else if (m_halted) begin
      m_fetch = 1'b0;
    end else if (m_fetch) begin
      m_word = rom[m_pc]; m_valid = 1'b1; m_fetch = 1'b0;
    end else if (m_valid) begin
      if (ready) begin
        m_valid = 1'b0;
        m_pc    = m_pc + 12'd1;
        if (m_word[7:4] == 4'hF) m_halted = 1'b1;
        else m_fetch = enable;
      end
    end else begin
      m_fetch = enable;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; load_addr = 12'h000; ready = 1'b0;
    tick(); tick();
    vectors++;
    if (obs() !== 22'h0) begin
      miscompares++; $display("FAIL reset_state: got %h want %h", obs(), 22'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obs() !== 22'h0 || obs() !== expv()) begin
        miscompares++; $display("FAIL reset_idle cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_stream();
    logic [8:0] want;
    enable = 1'b1; ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL stream cyc%0d: got %h want %h", i, obs(), expv());
      end
      want = (i == 2) ? 9'h112 : (i == 4) ? 9'h134 : (i == 6) ? 9'h156 : 9'h000;
      if (want[8]) begin
        vectors++;
        if ({valid, opcode, operand} !== want) begin
          miscompares++; $display("FAIL stream_word cyc%0d: got %h want %h", i, {valid, opcode, operand}, want);
        end
      end else begin
        vectors++;
        if (valid !== 1'b0) begin
          miscompares++; $display("FAIL stream_gap cyc%0d: valid got %b want 0", i, valid);
        end
      end
    end
    vectors++;
    if (direccion !== 12'h003) begin
      miscompares++; $display("FAIL stream_addr: got %h want 003", direccion);
    end
    enable = 1'b0; ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [11:0] a0;
    logic [7:0]  w0;
    int          n;
    load = 1'b1; load_addr = 12'h100; tick(); load = 1'b0;
    enable = 1'b1; ready = 1'b0;
    n = 0;
    while (!valid && n < 8) begin tick(); n++; end
    vectors++;
    if (valid !== 1'b1 || {opcode, operand} !== 8'h9A) begin
      miscompares++; $display("FAIL bp_first: got v=%b w=%h want v=1 w=9a", valid, {opcode, operand});
    end
    a0 = direccion; w0 = {opcode, operand};
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({direccion, valid, opcode, operand} !== {a0, 1'b1, w0} || obs() !== expv()) begin
        miscompares++; $display("FAIL bp_hold cyc%0d: got %h want %h", i, obs(), {a0, 1'b1, 1'b0, w0});
      end
    end
    ready = 1'b1; tick(); ready = 1'b0; enable = 1'b0;
    vectors++;
    if (direccion !== 12'h101 || valid !== 1'b0 || obs() !== expv()) begin
      miscompares++; $display("FAIL bp_accept: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_wrap();
    int n;
    load = 1'b1; load_addr = 12'hFFF; tick(); load = 1'b0;
    enable = 1'b1; ready = 1'b1;
    n = 0;
    while (!valid && n < 8) begin tick(); n++; end
    vectors++;
    if (valid !== 1'b1 || {opcode, operand} !== 8'h7C || direccion !== 12'hFFF) begin
      miscompares++; $display("FAIL wrap_word: got %h want fff/1/7c", obs());
    end
    tick();
    vectors++;
    if (direccion !== 12'h000 || valid !== 1'b0 || obs() !== expv()) begin
      miscompares++; $display("FAIL wrap_addr: got %h want %h", obs(), expv());
    end
    enable = 1'b0; ready = 1'b0;
  endtask

  task automatic test_halt();
    int n;
    load = 1'b1; load_addr = 12'h000; tick(); load = 1'b0;
    enable = 1'b1; ready = 1'b1;
    n = 0;
    while (!halted && n < 30) begin
      tick(); n++;
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL halt_run cyc%0d: got %h want %h", n, obs(), expv());
      end
    end
    vectors++;
    if (halted !== 1'b1 || direccion !== 12'h006 || valid !== 1'b0) begin
      miscompares++; $display("FAIL halt_enter: got %h want 006/0/1", obs());
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({direccion, valid, halted} !== {12'h006, 1'b0, 1'b1}) begin
        miscompares++; $display("FAIL halt_stay cyc%0d: got %h want 006/0/1", i, obs());
      end
    end
    load = 1'b1; load_addr = 12'h000; tick(); load = 1'b0; enable = 1'b0;
    vectors++;
    if ({direccion, valid, halted} !== {12'h000, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL halt_exit: got %h want 000/0/0", obs());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs() !== expv() || valid !== 1'b0) begin
        miscompares++; $display("FAIL halt_idle cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_load_in_hold();
    int n;
    enable = 1'b1; ready = 1'b0;
    n = 0;
    while (!valid && n < 8) begin tick(); n++; end
    load = 1'b1; load_addr = 12'h2A5; tick(); load = 1'b0; enable = 1'b0;
    vectors++;
    if (valid !== 1'b0 || direccion !== 12'h2A5 || obs() !== expv()) begin
      miscompares++; $display("FAIL load_hold: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_reset_in_fetch();
    enable = 1'b1; ready = 1'b0;
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    vectors++;
    if ({direccion, valid, halted} !== {12'h000, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL rst_fetch: got %h want 000/0/0", obs());
    end
    tick();
    vectors++;
    if (valid !== 1'b0 || obs() !== expv()) begin
      miscompares++; $display("FAIL rst_idle1: got %h want %h", obs(), expv());
    end
    tick();
    vectors++;
    if ({valid, opcode, operand} !== 9'h112 || obs() !== expv()) begin
      miscompares++; $display("FAIL rst_idle2: got %h want %h", obs(), expv());
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      load      = ($urandom_range(0, 29) == 0);
      load_addr = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom_range(0, 4095));
      enable    = ($urandom_range(0, 3) != 0);
      ready     = ($urandom_range(0, 1) != 0);
      tick();
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL random cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
    rst_n = 1'b1; load = 1'b0; enable = 1'b0; ready = 1'b0;
  endtask

  initial begin
    m_pc = 12'h000; m_word = 8'h00; m_valid = 1'b0; m_halted = 1'b0; m_fetch = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56;
    rom[3] = 8'h21; rom[4] = 8'h43; rom[5] = 8'hF0;
    rom[12'h100] = 8'h9A; rom[12'hFFF] = 8'h7C;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_halt();
    test_load_in_hold();
    test_reset_in_fetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
